// File: rtl/clock_period_meter.sv
// Measures the period and high time of a slow, asynchronous clock in clk_i cycles.
// Completed measurements are handed off over valid/ready; overrun and timeout flags are sticky.
module clock_period_meter #(
  parameter int CntWidth   = 16,
  parameter int SyncStages = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                slow_clk_i,
  input  logic                en_i,
  output logic                tick_o,
  output logic [CntWidth-1:0] period_o,
  output logic [CntWidth-1:0] high_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                overrun_o,
  output logic                timeout_o
);

  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);
  localparam logic [CntWidth-1:0] CntMax = '1;

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [SyncStages-1:0] r_sync;
  logic                  r_prev;
  logic                  r_tick;
  logic [CntWidth-1:0]   r_cnt;
  logic [CntWidth-1:0]   r_high_q;
  logic                  r_fall_seen;
  logic [CntWidth-1:0]   r_period;
  logic [CntWidth-1:0]   r_high;
  logic                  r_valid;
  logic                  r_overrun;
  logic                  r_timeout;

  logic w_sync;
  logic w_rise;
  logic w_fall;
  logic w_at_max;
  logic w_cnt_start;
  logic w_cnt_inc;
  logic w_load;
  logic w_fall_cap;
  logic w_timeout;

  assign w_sync   = r_sync[SyncStages-1];
  assign w_rise   = w_sync & ~r_prev;
  assign w_fall   = ~w_sync & r_prev;
  assign w_at_max = (r_cnt == CntMax);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Disabling always wins; a rise on the saturating cycle still closes the period.
  always_comb begin
    w_state_nxt = r_state;
    if (!en_i) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = ARM;
        ARM:     if (w_rise) w_state_nxt = MEASURE;
        MEASURE: if (!w_rise && w_at_max) w_state_nxt = ARM;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_cnt_start = 1'b0;
    w_cnt_inc   = 1'b0;
    w_load      = 1'b0;
    w_fall_cap  = 1'b0;
    w_timeout   = 1'b0;
    if (en_i && (r_state == ARM || r_state == MEASURE)) begin
      if (w_rise) begin
        w_cnt_start = 1'b1;
        w_load      = (r_state == MEASURE);
      end else if (w_at_max) begin
        w_timeout = 1'b1;
      end else begin
        w_cnt_inc  = 1'b1;
        w_fall_cap = w_fall && (r_state == MEASURE);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync      <= '0;
      r_prev      <= 1'b0;
      r_tick      <= 1'b0;
      r_cnt       <= '0;
      r_high_q    <= '0;
      r_fall_seen <= 1'b0;
      r_period    <= '0;
      r_high      <= '0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_sync <= {r_sync[SyncStages-2:0], slow_clk_i};
      r_prev <= w_sync;
      r_tick <= w_rise;

      // Counter is cleared in IDLE, on timeout and when disabled; it never wraps.
      if (w_cnt_start) begin
        r_cnt <= CntOne;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + CntOne;
      end else begin
        r_cnt <= '0;
      end

      if (w_cnt_start) begin
        r_fall_seen <= 1'b0;
      end else if (w_fall_cap) begin
        r_fall_seen <= 1'b1;
      end
      if (w_fall_cap) begin
        r_high_q <= r_cnt;
      end

      if (w_load) begin
        r_period <= r_cnt;
        r_high   <= r_fall_seen ? r_high_q : r_cnt;
      end

      if (w_load) begin
        r_valid <= 1'b1;
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end

      if (!en_i) begin
        r_overrun <= 1'b0;
      end else if (w_load && r_valid && !ready_i) begin
        r_overrun <= 1'b1;
      end

      if (!en_i) begin
        r_timeout <= 1'b0;
      end else if (w_timeout) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign tick_o    = r_tick;
  assign period_o  = r_period;
  assign high_o    = r_high;
  assign valid_o   = r_valid;
  assign overrun_o = r_overrun;
  assign timeout_o = r_timeout;

endmodule

// File: tb/tb_clock_period_meter.sv
// Scoreboard bench for clock_period_meter: a waveform-level model predicts results,
// a monitor pops and compares them on every accepted transfer.
module tb_clock_period_meter;
  localparam int W    = 16;
  localparam int MASK = 16383;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_i = 1'b1, en_i = 1'b1, slow_clk_i = 1'b0, ready_i = 1'b1;
  logic         tick_o, valid_o, overrun_o, timeout_o;
  logic [W-1:0] period_o, high_o;

  logic       t_slow = 1'b0, t_en = 1'b0, t_rdy = 1'b1;
  logic       t_tick, t_valid, t_ovr, t_to;
  logic [3:0] t_period, t_high;

  clock_period_meter #(.CntWidth(W), .SyncStages(2)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .slow_clk_i(slow_clk_i), .en_i(en_i),
    .tick_o(tick_o), .period_o(period_o), .high_o(high_o), .valid_o(valid_o),
    .ready_i(ready_i), .overrun_o(overrun_o), .timeout_o(timeout_o)
  );

  clock_period_meter #(.CntWidth(4), .SyncStages(2)) u_dut4 (
    .clk_i(clk), .rst_i(rst_i), .slow_clk_i(t_slow), .en_i(t_en),
    .tick_o(t_tick), .period_o(t_period), .high_o(t_high), .valid_o(t_valid),
    .ready_i(t_rdy), .overrun_o(t_ovr), .timeout_o(t_to)
  );

  logic c_rst = 1'b1, c_en = 1'b1, c_rdy = 1'b1, c_en4 = 1'b0;
  int pe = 0;
  always @(posedge clk) pe <= pe + 1;

  bit hist [0:MASK];
  bit rsth [0:MASK];

  typedef struct packed {
    logic [W-1:0] per;
    logic [W-1:0] hi;
  } res_t;

  res_t q[$];
  res_t held;
  bit   hold_sb = 1'b0, have_rise = 1'b0, have_fall = 1'b0, prev_s = 1'b0, tick_on = 1'b0;
  int   last_rise = 0, fall_at = 0;
  int   n_vec = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int per, input int hi);
    res_t r;
    r.per = per[W-1:0];
    r.hi  = hi[W-1:0];
    if (hold_sb) held = r;
    else q.push_back(r);
  endtask

  // One clock: apply controls and slow clocks, then update the waveform model.
  // A period is the distance between two applied rising edges; high is rise-to-fall.
  task automatic step(input logic s, input logic s4);
    int si;
    @(posedge clk);
    #1;
    rst_i = c_rst; en_i = c_en; ready_i = c_rdy; slow_clk_i = s;
    t_en = c_en4; t_slow = s4;
    si = pe + 1;
    rsth[si & MASK] = c_rst;
    hist[si & MASK] = c_rst ? 1'b0 : s;
    if (c_rst) begin
      have_rise = 1'b0;
      prev_s    = 1'b0;
    end else begin
      if (s && !prev_s && c_en) begin
        if (have_rise) push(si - last_rise, have_fall ? fall_at - last_rise : si - last_rise);
        have_rise = 1'b1;
        last_rise = si;
        have_fall = 1'b0;
      end else if (!s && prev_s && have_rise) begin
        have_fall = 1'b1;
        fall_at   = si;
      end
      if (!c_en) have_rise = 1'b0;
      prev_s = s;
    end
  endtask

  task automatic div(input int p, input int h, input int n);
    for (int k = 0; k < n; k++)
      for (int j = 0; j < p; j++) step(j < h, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tick"}, 32'(tick_o), 0);
    chk({tag, "_valid"}, 32'(valid_o), 0);
    chk({tag, "_overrun"}, 32'(overrun_o), 0);
    chk({tag, "_timeout"}, 32'(timeout_o), 0);
    chk({tag, "_period"}, 32'(period_o), 0);
    chk({tag, "_high"}, 32'(high_o), 0);
    chk({tag, "_t_valid"}, 32'(t_valid), 0);
    chk({tag, "_t_timeout"}, 32'(t_to), 0);
  endtask

  always @(negedge clk) begin : monitor
    res_t e;
    if (tick_on && pe >= 3)
      chk("tick", 32'(tick_o),
          rsth[pe & MASK] ? 0 : 32'(hist[(pe - 2) & MASK] & ~hist[(pe - 3) & MASK]));
    if (!rst_i && valid_o && ready_i) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 32'(valid_o), 0);
      end else begin
        e = q.pop_front();
        chk("period", 32'(period_o), 32'(e.per));
        chk("high", 32'(high_o), 32'(e.hi));
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, %0d vectors, %0d miscompares", n_vec, n_fail);
    $fatal(1);
  end

  initial begin
    int p, h, c0, got;
    // Reset while enabled and with the slow clock toggling.
    c_rst = 1'b1; c_en = 1'b1; c_rdy = 1'b1;
    for (int i = 0; i < 6; i++) step(i[0], 1'b0);
    c_rst = 1'b0;
    step(1'b1, 1'b0);
    @(negedge clk);
    chk_zero("rst");
    tick_on = 1'b1;
    idle(2);

    div(4, 2, 10);
    div(10, 2, 6);
    idle(8);
    chk("drain_div", q.size(), 0);

    // Consumer stalled for several periods: later loads overwrite.
    c_rdy = 1'b0; hold_sb = 1'b1;
    div(4, 2, 4);
    idle(5);
    @(negedge clk);
    chk("stall_valid", 32'(valid_o), 1);
    chk("stall_overrun", 32'(overrun_o), 1);
    chk("stall_period", 32'(period_o), 4);
    chk("stall_high", 32'(high_o), 2);

    // One-cycle disable mid-measurement keeps the pending result, clears flags.
    c_en = 1'b0; step(1'b0, 1'b0);
    c_en = 1'b1; step(1'b0, 1'b0);
    @(negedge clk);
    chk("dis_overrun", 32'(overrun_o), 0);
    chk("dis_timeout", 32'(timeout_o), 0);
    chk("dis_valid", 32'(valid_o), 1);
    chk("dis_period", 32'(period_o), 4);
    chk("dis_high", 32'(high_o), 2);

    hold_sb = 1'b0;
    q.push_back(held);
    c_rdy = 1'b1; step(1'b0, 1'b0);
    c_rdy = 1'b0; step(1'b0, 1'b0);
    @(negedge clk);
    chk("accept_valid_drop", 32'(valid_o), 0);
    c_rdy = 1'b1;
    div(4, 2, 4);

    // Random periods and duty, consumer never stalls two cycles in a row.
    for (int k = 0; k < 150; k++) begin
      p = ($urandom_range(0, 19) == 0) ? int'($urandom_range(25, 300)) : int'($urandom_range(2, 24));
      h = $urandom_range(1, p - 1);
      for (int j = 0; j < p; j++) begin
        c_rdy = !c_rdy ? 1'b1 : ($urandom_range(0, 3) != 0);
        step(j < h, 1'b0);
      end
    end
    c_rdy = 1'b1;
    idle(8);
    chk("drain_rand", q.size(), 0);
    chk("rand_overrun", 32'(overrun_o), 0);
    chk("rand_timeout", 32'(timeout_o), 0);

    // Reset in the middle of operation with a pending, overrun result.
    c_rdy = 1'b0; hold_sb = 1'b1;
    div(4, 2, 3);
    c_rst = 1'b1;
    for (int i = 0; i < 3; i++) step(i[0], 1'b0);
    c_rst = 1'b0;
    step(1'b0, 1'b0);
    @(negedge clk);
    chk_zero("mid_rst");
    hold_sb = 1'b0; c_rdy = 1'b1;
    div(4, 2, 3);
    idle(4);

    // Narrow counter instance: stall after a single rise.
    c_en4 = 1'b1;
    idle(3);
    step(1'b0, 1'b1);
    c0 = pe + 1;
    step(1'b0, 1'b1);
    while (pe < c0 + 16) step(1'b0, 1'b0);
    @(negedge clk);
    chk("t_timeout_early", 32'(t_to), 0);
    step(1'b0, 1'b0);
    @(negedge clk);
    chk("t_timeout", 32'(t_to), 1);
    chk("t_no_valid", 32'(t_valid), 0);

    step(1'b0, 1'b1); step(1'b0, 1'b1);
    idle(3);
    @(negedge clk);
    chk("t_one_rise", 32'(t_valid), 0);
    step(1'b0, 1'b1); step(1'b0, 1'b1);
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      @(negedge clk);
      if (t_valid) got = 1;
      else step(1'b0, 1'b0);
    end
    chk("t_result_seen", got, 1);
    chk("t_period", 32'(t_period), 5);
    chk("t_high", 32'(t_high), 2);
    chk("t_timeout_sticky", 32'(t_to), 1);
    c_en4 = 1'b0; step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    @(negedge clk);
    chk("t_timeout_cleared", 32'(t_to), 0);

    idle(6);
    chk("drain_final", q.size(), 0);
    chk("final_overrun", 32'(overrun_o), 0);
    chk("final_timeout", 32'(timeout_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
